systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
Operand sequencer that drives the input edge of an NxN systolic array, upstream of systolicarray_1-style cores.
- Accepts one packed pair of NxN fixed-point matrices (A, B) through a valid/ready handshake.
- Emits them as diagonally skewed streams: A rows enter the left edge, B columns enter the top edge.
- Follows the operands with zero-flush cycles and frame markers so the array can clear and then retire its accumulators.

Parameters:
SIZE, 8, element width in bits (two's complement fixed point)
DECIMAL, 4, fractional bits; carried for documentation and checks only, no arithmetic here
N, 2, matrix dimension (N >= 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  matrix pair offered
in_ready  out  1  feeder can accept a pair
in_a  in  N*N*SIZE  matrix A; element (r,c) at bits [(r*N+c)*SIZE +: SIZE]
in_b  in  N*N*SIZE  matrix B; same packing
a_row_out  out  N*SIZE  left-edge operands; row i at bits [i*SIZE +: SIZE]
b_col_out  out  N*SIZE  top-edge operands; column j at bits [j*SIZE +: SIZE]
feed_valid  out  1  operand step present
frame_start  out  1  pulse on step 0; array clears accumulators
feed_last  out  1  high on final operand step
frame_done  out  1  pulse on last flush cycle; array result is final
busy  out  1  high in FEED or DRAIN

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, step counter 0, captured matrices 0.
  - All outputs 0 except in_ready=1.
  - Reset mid-frame aborts the frame immediately; no frame_done is produced.
- States:
  - IDLE: in_ready=1, busy=0, outputs 0.
  - Accept on a rising edge with in_valid & in_ready.
  - At that same edge: capture in_a/in_b, go to FEED with t=0, and register step-0 outputs.
  - No bubble between accept and step 0.
- FEED, steps t = 0 .. 2N-2, one per clock:
  - a_row_out row i = A[i][t-i] if 0 <= t-i < N, else 0.
  - b_col_out column j = B[t-j][j] if 0 <= t-j < N, else 0.
  - feed_valid=1 throughout.
  - frame_start=1 only at t=0.
  - feed_last=1 only at t=2N-2.
  - After t=2N-2 go to DRAIN.
- DRAIN, N cycles:
  - a_row_out=0, b_col_out=0, feed_valid=0.
  - frame_done=1 on the last DRAIN cycle; next state IDLE.
- Timing:
  - busy=1 for 3N-1 cycles per frame.
  - in_ready=0 throughout FEED and DRAIN; in_valid there is ignored; in_a/in_b may change freely.
  - in_ready returns to 1 the cycle after frame_done.
  - Minimum frame-to-frame spacing is 3N cycles.
- Widths: values pass bit-exact, no sign extension, rounding or arithmetic.
- Out-of-range skew slots are forced to 0, never stale data.
- All outputs are registered.

Optional Feature:
Macro FEEDER_STALL_EN.
- Defined:
  - Adds input port stall (1 bit).
  - While stall=1 in FEED or DRAIN: state, counters and all outputs hold their values. frame_start, feed_last and frame_done stay high if already high, so downstream qualifies them with not-stall.
  - stall has no effect in IDLE; the handshake is unaffected.
  - Reset overrides stall.
- Undefined: no stall port; the sequence always advances every cycle.

Decomposition:
- Package systolic_pkg holds:
  - state encoding (IDLE, FEED, DRAIN)
  - default SIZE/DECIMAL/N
  - localparams STEPS=2N-1 and DRAIN_CYCLES=N
  - counter width $clog2(3N)
- One sub-module, skew_select: combinational; picks per-row/column elements for step t and zero-fills out-of-range slots. Instantiated twice, once for A (row-wise) and once for B (column-wise).

Test Plan:
- Reset/idle: hold rst=0 then release.
  - in_ready=1, all other outputs 0.
  - in_valid=0 for 10 cycles keeps busy=0.
- Basic frame, N=2, in_a=32'h08101008, in_b=32'h40302010:
  - a_row_out 0x0008, 0x1010, 0x0800 over steps 0, 1, 2.
  - b_col_out 0x0010, 0x2030, 0x4000 over steps 0, 1, 2.
  - frame_start at step 0, feed_last at step 2.
  - Then 2 zero DRAIN cycles, frame_done on the 2nd.
  - busy spans 5 cycles.
- Busy rejection: assert in_valid with new data throughout the frame.
  - in_ready stays 0 and outputs match the first frame exactly.
  - Second pair accepted on the cycle after frame_done.
- Reset mid-frame: drop rst at step 1.
  - Outputs go 0 immediately, no frame_done, in_ready=1 after release.
  - A new frame then runs cleanly.
- Back-to-back frames: hold in_valid=1 with two different pairs.
  - Accepts are exactly 3N=6 cycles apart; second sequence is correct.
- FEEDER_STALL_EN build: stall=1 for 3 cycles at step 1.
  - Outputs hold 0x1010/0x2030 for the 3 stalled cycles, then resume at step 2.
  - busy spans 8 cycles.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array operand feeder: state encoding,
// default geometry and helpers that derive step/drain counts from N.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_SIZE    = 8;
  localparam int DEF_DECIMAL = 4;
  localparam int DEF_N       = 2;

  localparam int STEPS        = 2 * DEF_N - 1;
  localparam int DRAIN_CYCLES = DEF_N;
  localparam int CNT_W        = $clog2(3 * DEF_N);

  function automatic int steps_of(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int cnt_width_of(input int n);
    return $clog2(3 * n);
  endfunction

endpackage

// File: rtl/skew_select.sv
// Combinational skew slot picker: for step t, lane k takes the element on
// anti-diagonal t of a packed NxN matrix, or zero when that slot is empty.
module skew_select
  import systolic_pkg::*;
#(
  parameter int SIZE   = DEF_SIZE,
  parameter int N      = DEF_N,
  parameter int CW     = cnt_width_of(DEF_N),
  parameter bit COLUMN = 1'b0
) (
  input  logic [N*N*SIZE-1:0] mat,
  input  logic [CW-1:0]       step,
  output logic [N*SIZE-1:0]   vec
);

  // Row mode: lane k = M[k][t-k]; column mode: lane k = M[t-k][k].
  always_comb begin
    // NOTE: every lane gets a zero default first, so unused slots never hold
    // stale data and no latch is inferred.
    vec = '0;
    for (int k = 0; k < N; k++) begin
      int off;
      off = int'(step) - k;
      if (off >= 0 && off < N) begin
        if (COLUMN) vec[k*SIZE +: SIZE] = mat[(off*N + k)*SIZE +: SIZE];
        else        vec[k*SIZE +: SIZE] = mat[(k*N + off)*SIZE +: SIZE];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Feeds one captured (A, B) matrix pair into an NxN systolic array as skewed
// edge streams, then N zero-flush cycles. `FEEDER_STALL_EN adds a stall input.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int SIZE    = DEF_SIZE,
  parameter int DECIMAL = DEF_DECIMAL,
  parameter int N       = DEF_N
) (
  input  logic                clk,
  input  logic                rst,
`ifdef FEEDER_STALL_EN
  input  logic                stall,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*N*SIZE-1:0] in_a,
  input  logic [N*N*SIZE-1:0] in_b,
  output logic [N*SIZE-1:0]   a_row_out,
  output logic [N*SIZE-1:0]   b_col_out,
  output logic                feed_valid,
  output logic                frame_start,
  output logic                feed_last,
  output logic                frame_done,
  output logic                busy
);

  localparam int NSTEPS = steps_of(N);
  localparam int NDRAIN = N;
  localparam int CW     = cnt_width_of(N);

  localparam logic [CW-1:0] LAST_STEP  = CW'(NSTEPS - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(NDRAIN - 1);

  if (N < 2) begin : g_bad_n
    $error("systolic_feeder: N must be at least 2");
  end
  if (DECIMAL < 0 || DECIMAL >= SIZE) begin : g_bad_decimal
    $error("systolic_feeder: DECIMAL must lie in [0, SIZE)");
  end

  state_t                state_q, state_d;
  logic [CW-1:0]         t_q, t_d;
  logic [N*N*SIZE-1:0]   cap_a, cap_b;
  logic [N*N*SIZE-1:0]   src_a, src_b;
  logic [N*SIZE-1:0]     a_next, b_next;
  logic                  accept;
  logic                  hold;

  assign accept = (state_q == IDLE) && in_valid;

`ifdef FEEDER_STALL_EN
  assign hold = stall && (state_q != IDLE);
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = FEED;
          t_d     = '0;
        end
      end
      FEED: begin
        if (t_q == LAST_STEP) begin
          state_d = DRAIN;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      DRAIN: begin
        if (t_q == LAST_DRAIN) begin
          state_d = IDLE;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Step 0 is produced at the accept edge, so it must come straight from the
  // input bus rather than from the not-yet-loaded capture registers.
  assign src_a = (state_q == IDLE) ? in_a : cap_a;
  assign src_b = (state_q == IDLE) ? in_b : cap_b;

  skew_select #(.SIZE(SIZE), .N(N), .CW(CW), .COLUMN(1'b0)) u_skew_a (
    .mat  (src_a),
    .step (t_d),
    .vec  (a_next)
  );

  skew_select #(.SIZE(SIZE), .N(N), .CW(CW), .COLUMN(1'b1)) u_skew_b (
    .mat  (src_b),
    .step (t_d),
    .vec  (b_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge
      // values, so state and outputs step together without ordering races.
      state_q <= IDLE;
      t_q     <= '0;
    end else if (!hold) begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the capture registers are reset too, so nothing from an aborted
      // frame can leak into a later one.
      cap_a <= '0;
      cap_b <= '0;
    end else if (accept) begin
      cap_a <= in_a;
      cap_b <= in_b;
    end
  end

  // Outputs are registered from the next state, so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_row_out   <= '0;
      b_col_out   <= '0;
      feed_valid  <= 1'b0;
      frame_start <= 1'b0;
      feed_last   <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      in_ready    <= 1'b1;
    end else if (!hold) begin
      a_row_out   <= (state_d == FEED) ? a_next : '0;
      b_col_out   <= (state_d == FEED) ? b_next : '0;
      feed_valid  <= (state_d == FEED);
      frame_start <= (state_d == FEED)  && (t_d == '0);
      feed_last   <= (state_d == FEED)  && (t_d == LAST_STEP);
      frame_done  <= (state_d == DRAIN) && (t_d == LAST_DRAIN);
      busy        <= (state_d != IDLE);
      in_ready    <= (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=2, SIZE=8); build with
// FEEDER_STALL_EN defined to also exercise the stall input.
module tb_systolic_feeder;

  localparam int SIZE = 8;
  localparam int N    = 2;
  localparam int MW   = N*N*SIZE;
  localparam int VW   = N*SIZE;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] in_a, in_b;
  logic [VW-1:0] a_row_out, b_col_out;
  logic          feed_valid, frame_start, feed_last, frame_done, busy;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int acc_last = -1;
  int acc_prev = -1;

  always #5 clk = ~clk;

  systolic_feeder #(.SIZE(SIZE), .DECIMAL(4), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef FEEDER_STALL_EN
    .stall       (stall),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .a_row_out   (a_row_out),
    .b_col_out   (b_col_out),
    .feed_valid  (feed_valid),
    .frame_start (frame_start),
    .feed_last   (feed_last),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && in_valid && in_ready) begin
      acc_prev <= acc_last;
      acc_last <= cyc;
    end
  end

  function automatic logic [63:0] pack(input logic [15:0] a, input logic [15:0] b,
                                       input logic fv, input logic fs, input logic fl,
                                       input logic fd, input logic bz, input logic rd);
    return {26'd0, a, b, fv, fs, fl, fd, bz, rd};
  endfunction

  function automatic logic [63:0] obs();
    return pack(a_row_out, b_col_out, feed_valid, frame_start, feed_last,
                frame_done, busy, in_ready);
  endfunction

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; offers (pa, pb) and checks the whole frame, ending on
  // the idle negedge after frame_done. keep leaves in_valid high with (na, nb).
  task automatic frame(input string tag, input logic [31:0] pa, input logic [31:0] pb,
                       input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                       input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2,
                       input bit keep, input logic [31:0] na, input logic [31:0] nb);
    in_valid = 1'b1;
    in_a     = pa;
    in_b     = pb;
    @(negedge clk);
    if (keep) begin
      in_a = na;
      in_b = nb;
    end else begin
      in_valid = 1'b0;
    end
    check({tag, ".step0"}, obs(), pack(a0, b0, 1, 1, 0, 0, 1, 0));
    @(negedge clk);
    check({tag, ".step1"}, obs(), pack(a1, b1, 1, 0, 0, 0, 1, 0));
    @(negedge clk);
    check({tag, ".step2"}, obs(), pack(a2, b2, 1, 0, 1, 0, 1, 0));
    @(negedge clk);
    check({tag, ".drain0"}, obs(), pack(16'h0, 16'h0, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    check({tag, ".drain1"}, obs(), pack(16'h0, 16'h0, 0, 0, 0, 1, 1, 0));
    @(negedge clk);
    check({tag, ".idle"}, obs(), pack(16'h0, 16'h0, 0, 0, 0, 0, 0, 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    stall    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;

    // Reset and idle
    #1 rst = 1'b0;
    #1 check("reset.async", obs(), pack(16'h0, 16'h0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    check("reset.held", obs(), pack(16'h0, 16'h0, 0, 0, 0, 0, 0, 1));
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle.noval", obs(), pack(16'h0, 16'h0, 0, 0, 0, 0, 0, 1));
    end

    // Basic frame, with in_valid held on a new pair throughout
    frame("basic", 32'h08101008, 32'h40302010,
          16'h0008, 16'h1010, 16'h0800, 16'h0010, 16'h2030, 16'h4000,
          1'b1, 32'h04030201, 32'h0D0C0B0A);
    // Second pair accepted on the cycle after frame_done
    frame("second", 32'h04030201, 32'h0D0C0B0A,
          16'h0001, 16'h0302, 16'h0400, 16'h000A, 16'h0B0C, 16'h0D00,
          1'b0, 32'h0, 32'h0);

    // Reset mid-frame at step 1
    in_valid = 1'b1;
    in_a     = 32'h08101008;
    in_b     = 32'h40302010;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort.step0", obs(), pack(16'h0008, 16'h0010, 1, 1, 0, 0, 1, 0));
    @(negedge clk);
    check("abort.step1", obs(), pack(16'h1010, 16'h2030, 1, 0, 0, 0, 1, 0));
    #1 rst = 1'b0;
    #1 check("abort.async", obs(), pack(16'h0, 16'h0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    check("abort.held", obs(), pack(16'h0, 16'h0, 0, 0, 0, 0, 0, 1));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort.nodone", obs(), pack(16'h0, 16'h0, 0, 0, 0, 0, 0, 1));
    end
    frame("after_abort", 32'h08101008, 32'h40302010,
          16'h0008, 16'h1010, 16'h0800, 16'h0010, 16'h2030, 16'h4000,
          1'b0, 32'h0, 32'h0);

    // Back-to-back frames with in_valid held high
    frame("b2b.first", 32'h04030201, 32'h0D0C0B0A,
          16'h0001, 16'h0302, 16'h0400, 16'h000A, 16'h0B0C, 16'h0D00,
          1'b1, 32'hFF807F01, 32'h55667788);
    frame("b2b.second", 32'hFF807F01, 32'h55667788,
          16'h0001, 16'h807F, 16'hFF00, 16'h0088, 16'h7766, 16'h5500,
          1'b0, 32'h0, 32'h0);
    check("b2b.spacing", 64'(acc_last - acc_prev), 64'd6);

`ifdef FEEDER_STALL_EN
    // Stall for 3 cycles while step 1 is on the outputs
    in_valid = 1'b1;
    in_a     = 32'h08101008;
    in_b     = 32'h40302010;
    @(negedge clk);
    in_valid = 1'b0;
    check("stall.step0", obs(), pack(16'h0008, 16'h0010, 1, 1, 0, 0, 1, 0));
    @(negedge clk);
    check("stall.step1", obs(), pack(16'h1010, 16'h2030, 1, 0, 0, 0, 1, 0));
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall.hold", obs(), pack(16'h1010, 16'h2030, 1, 0, 0, 0, 1, 0));
    end
    stall = 1'b0;
    @(negedge clk);
    check("stall.step2", obs(), pack(16'h0800, 16'h4000, 1, 0, 1, 0, 1, 0));
    @(negedge clk);
    check("stall.drain0", obs(), pack(16'h0, 16'h0, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    check("stall.drain1", obs(), pack(16'h0, 16'h0, 0, 0, 0, 1, 1, 0));
    @(negedge clk);
    check("stall.idle", obs(), pack(16'h0, 16'h0, 0, 0, 0, 0, 0, 1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
